// File: rtl/qkd_pair_bank_sched_pkg.sv
// Shared types and constants for the QKD pair-bank session scheduler.
package qkd_pkg;

  localparam int BYTE_W  = 8;
  localparam int BASIS_W = 2;

  typedef enum logic [2:0] {
    SCHED_IDLE     = 3'd0,
    SCHED_WAIT_REQ = 3'd1,
    SCHED_INIT     = 3'd2,
    SCHED_MEASURE  = 3'd3,
    SCHED_CONFIRM  = 3'd4,
    SCHED_DONE     = 3'd5
  } sched_state_e;

  typedef enum logic [2:0] {
    ERR_OK        = 3'd0,
    ERR_EXHAUSTED = 3'd1,
    ERR_TIMEOUT   = 3'd2,
    ERR_MISMATCH  = 3'd3,
    ERR_FAULT     = 3'd4,
    ERR_ABORT     = 3'd5
  } sched_err_e;

endpackage

// File: rtl/qkd_pair_bank_sched_if.sv
// Party basis handshakes plus the pair-bank strobe/data bus. The slave side is
// the scheduler; the master side is the parties together with the pair bank.
interface qkd_pair_bank_sched_if #(
  parameter int NUM_PAIRS = 16
);

  logic                              req_a_valid;
  logic                              req_a_ready;
  logic [qkd_pkg::BASIS_W-1:0]       req_a_basis;
  logic                              req_b_valid;
  logic                              req_b_ready;
  logic [qkd_pkg::BASIS_W-1:0]       req_b_basis;
  logic                              res_valid;
  logic                              res_sifted;
  logic [NUM_PAIRS-1:0]              pair_init;
  logic [NUM_PAIRS-1:0]              pair_read_a;
  logic [NUM_PAIRS-1:0]              pair_read_b;
  logic [qkd_pkg::BASIS_W-1:0]       pair_basis_a;
  logic [qkd_pkg::BASIS_W-1:0]       pair_basis_b;
  logic [qkd_pkg::BYTE_W*NUM_PAIRS-1:0] pair_out_a;
  logic [qkd_pkg::BYTE_W*NUM_PAIRS-1:0] pair_out_b;
  logic [NUM_PAIRS-1:0]              pair_valid_a;
  logic [NUM_PAIRS-1:0]              pair_valid_b;
  logic [NUM_PAIRS-1:0]              pair_fuse_fire;

  modport master (
    output req_a_valid, req_a_basis, req_b_valid, req_b_basis,
    output pair_out_a, pair_out_b, pair_valid_a, pair_valid_b, pair_fuse_fire,
    input  req_a_ready, req_b_ready, res_valid, res_sifted,
    input  pair_init, pair_read_a, pair_read_b, pair_basis_a, pair_basis_b
  );

  modport slave (
    input  req_a_valid, req_a_basis, req_b_valid, req_b_basis,
    input  pair_out_a, pair_out_b, pair_valid_a, pair_valid_b, pair_fuse_fire,
    output req_a_ready, req_b_ready, res_valid, res_sifted,
    output pair_init, pair_read_a, pair_read_b, pair_basis_a, pair_basis_b
  );

endinterface

// File: rtl/qkd_pair_bank_sched_slot_pick.sv
// Combinational priority encoder: index of the lowest clear bit of the spent
// map, with none_free raised when every slot has been consumed.
module qkd_slot_pick #(
  parameter int NUM_PAIRS = 16,
  parameter int SLOT_W    = $clog2(NUM_PAIRS)
) (
  input  logic [NUM_PAIRS-1:0] spent,
  output logic [SLOT_W-1:0]    idx,
  output logic                 none_free
);

  // Scan downward so the last hit, the lowest free index, wins.
  always_comb begin
    idx       = '0;
    none_free = 1'b1;
    for (int i = NUM_PAIRS - 1; i >= 0; i--) begin
      if (!spent[i]) begin
        idx       = i[SLOT_W-1:0];
        none_free = 1'b0;
      end else begin
        none_free = none_free;
      end
    end
  end

endmodule

// File: rtl/qkd_pair_bank_sched.sv
// Session scheduler: collects per-round bases from two parties, consumes one
// unspent entangled-pair slot per round, sifts the result and builds a key.
module qkd_pair_bank_sched
  import qkd_pkg::*;
#(
  parameter int NUM_PAIRS = 16,
  parameter int KEY_BYTES = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  qkd_pair_bank_sched_if.slave        bus,
  output logic                        busy,
  output logic [BYTE_W*KEY_BYTES-1:0] key,
  output logic                        key_valid,
  output logic [2:0]                  err,
  output logic [NUM_PAIRS-1:0]        spent
);

  localparam int SLOT_W = $clog2(NUM_PAIRS);
  localparam int CNT_W  = $clog2(KEY_BYTES + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int KEY_W  = BYTE_W * KEY_BYTES;

  localparam logic [2:0] S_IDLE     = SCHED_IDLE;
  localparam logic [2:0] S_WAIT_REQ = SCHED_WAIT_REQ;
  localparam logic [2:0] S_INIT     = SCHED_INIT;
  localparam logic [2:0] S_MEASURE  = SCHED_MEASURE;
  localparam logic [2:0] S_CONFIRM  = SCHED_CONFIRM;
  localparam logic [2:0] S_DONE     = SCHED_DONE;

  logic [2:0]         state, state_c, state_n;
  logic [2:0]         err_c, err_n;
  logic               have_a, have_b, have_a_n, have_b_n;
  logic [BASIS_W-1:0] basis_a, basis_b, basis_a_n, basis_b_n;
  logic [SLOT_W-1:0]  slot, slot_n, pick_idx;
  logic               none_free;
  logic [WAIT_W-1:0]  wait_cnt, wait_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [KEY_W-1:0]   key_n;
  logic [NUM_PAIRS-1:0] spent_n, slot_oh;
  logic [BYTE_W-1:0]  cap_a, cap_b, live_a, live_b;
  logic               cap_va, cap_vb;
  logic               hs_a, hs_b, sift_live, sift_cap, in_session;

  qkd_slot_pick #(
    .NUM_PAIRS (NUM_PAIRS),
    .SLOT_W    (SLOT_W)
  ) u_pick (
    .spent     (spent),
    .idx       (pick_idx),
    .none_free (none_free)
  );

  assign hs_a       = bus.req_a_valid & bus.req_a_ready;
  assign hs_b       = bus.req_b_valid & bus.req_b_ready;
  assign slot_oh    = NUM_PAIRS'(1) << slot;
  assign live_a     = bus.pair_out_a[slot*BYTE_W +: BYTE_W];
  assign live_b     = bus.pair_out_b[slot*BYTE_W +: BYTE_W];
  assign sift_live  = bus.pair_valid_a[slot] & bus.pair_valid_b[slot] & (live_a == live_b);
  assign sift_cap   = cap_va & cap_vb & (cap_a == cap_b);
  assign in_session = (state != S_IDLE) && (state != S_DONE);

  // Pair-bank strobes decode directly from state and the selected slot.
  always_comb begin
    bus.pair_init   = (state == S_INIT)    ? slot_oh : '0;
    bus.pair_read_a = (state == S_MEASURE) ? slot_oh : '0;
    bus.pair_read_b = (state == S_MEASURE) ? slot_oh : '0;
  end

  assign bus.pair_basis_a = basis_a;
  assign bus.pair_basis_b = basis_b;

  // Next-state and datapath update for the session FSM.
  always_comb begin
    state_c   = state;
    err_c     = err;
    have_a_n  = have_a;
    have_b_n  = have_b;
    basis_a_n = basis_a;
    basis_b_n = basis_b;
    slot_n    = slot;
    wait_n    = wait_cnt;
    cnt_n     = cnt;
    key_n     = key;
    spent_n   = spent;
    case (state)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          key_n    = '0;
          cnt_n    = '0;
          err_c    = ERR_OK;
          wait_n   = '0;
          have_a_n = 1'b0;
          have_b_n = 1'b0;
          if (&spent) begin
            state_c = S_DONE;
            err_c   = ERR_EXHAUSTED;
          end else begin
            state_c = S_WAIT_REQ;
          end
        end else begin
          state_c = state;
        end
      end
      S_WAIT_REQ: begin
        if (hs_a) begin
          have_a_n  = 1'b1;
          basis_a_n = bus.req_a_basis;
        end else begin
          have_a_n  = have_a;
        end
        if (hs_b) begin
          have_b_n  = 1'b1;
          basis_b_n = bus.req_b_basis;
        end else begin
          have_b_n  = have_b;
        end
        if (have_a_n && have_b_n) begin
          state_c = S_INIT;
          slot_n  = pick_idx;
        end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
          state_c = S_DONE;
          err_c   = ERR_TIMEOUT;
        end else begin
          wait_n  = wait_cnt + WAIT_W'(1);
        end
      end
      S_INIT: begin
        state_c = S_MEASURE;
      end
      S_MEASURE: begin
        spent_n[slot] = 1'b1;
        state_c       = S_CONFIRM;
      end
      S_CONFIRM: begin
        // A slot whose fuse did not fire was dead or tampered: its data is untrusted.
        if (!bus.pair_fuse_fire[slot]) begin
          state_c = S_DONE;
          err_c   = ERR_FAULT;
        end else if (cap_va && cap_vb && (cap_a != cap_b)) begin
          state_c = S_DONE;
          err_c   = ERR_MISMATCH;
        end else begin
          if (sift_cap) begin
            key_n = {key[KEY_W-BYTE_W-1:0], cap_a};
            cnt_n = cnt + CNT_W'(1);
          end else begin
            cnt_n = cnt;
          end
          if (cnt_n == CNT_W'(KEY_BYTES)) begin
            state_c = S_DONE;
            err_c   = ERR_OK;
          end else if (none_free) begin
            state_c = S_DONE;
            err_c   = ERR_EXHAUSTED;
          end else begin
            state_c  = S_WAIT_REQ;
            have_a_n = 1'b0;
            have_b_n = 1'b0;
            wait_n   = '0;
          end
        end
      end
      default: begin
        state_c = S_IDLE;
      end
    endcase
    state_n = (abort && in_session) ? S_DONE : state_c;
    err_n   = (abort && in_session) ? ERR_ABORT : err_c;
  end

  // State, datapath and registered outputs; outputs are set from next-state values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      err             <= ERR_OK;
      have_a          <= 1'b0;
      have_b          <= 1'b0;
      basis_a         <= '0;
      basis_b         <= '0;
      slot            <= '0;
      wait_cnt        <= '0;
      cnt             <= '0;
      key             <= '0;
      spent           <= '0;
      cap_a           <= '0;
      cap_b           <= '0;
      cap_va          <= 1'b0;
      cap_vb          <= 1'b0;
      busy            <= 1'b0;
      key_valid       <= 1'b0;
      bus.req_a_ready <= 1'b0;
      bus.req_b_ready <= 1'b0;
      bus.res_valid   <= 1'b0;
      bus.res_sifted  <= 1'b0;
    end else begin
      state           <= state_n;
      err             <= err_n;
      have_a          <= have_a_n;
      have_b          <= have_b_n;
      basis_a         <= basis_a_n;
      basis_b         <= basis_b_n;
      slot            <= slot_n;
      wait_cnt        <= wait_n;
      cnt             <= cnt_n;
      key             <= key_n;
      spent           <= spent_n;
      if (state == S_MEASURE) begin
        cap_a  <= live_a;
        cap_b  <= live_b;
        cap_va <= bus.pair_valid_a[slot];
        cap_vb <= bus.pair_valid_b[slot];
      end
      busy            <= (state_n != S_IDLE) && (state_n != S_DONE);
      key_valid       <= (state_n == S_DONE) && (err_n == ERR_OK);
      bus.req_a_ready <= (state_n == S_WAIT_REQ) && !have_a_n;
      bus.req_b_ready <= (state_n == S_WAIT_REQ) && !have_b_n;
      bus.res_valid   <= (state_n == S_CONFIRM);
      bus.res_sifted  <= (state_n == S_CONFIRM) && sift_live;
    end
  end

endmodule

// File: tb/tb_qkd_pair_bank_sched.sv
// Directed bench: a 16-slot and a 2-slot scheduler driven by pair-bank stubs
// with programmable basis and byte values.
module tb_qkd_pair_bank_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1, abort0;
  logic        va, vb;
  logic [1:0]  ba, bb;
  bit          suppress, mm, cur;
  int          nvec = 0;
  int          nerr = 0;

  logic        busy0, key_valid0, busy1, key_valid1;
  logic [31:0] key0, key1;
  logic [2:0]  err0, err1;
  logic [15:0] spent0;
  logic [1:0]  spent1;

  logic [127:0] out0a, out0b;
  logic [15:0]  out1a, out1b;
  logic [15:0]  fuse0;
  logic [1:0]   fuse1;

  logic        rdy_a_m, rdy_b_m, resv_m, ress_m;
  logic [15:0] init_m;

  qkd_pair_bank_sched_if #(.NUM_PAIRS(16)) bus0 ();
  qkd_pair_bank_sched_if #(.NUM_PAIRS(2))  bus1 ();

  qkd_pair_bank_sched #(.NUM_PAIRS(16), .KEY_BYTES(4), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0), .bus(bus0),
    .busy(busy0), .key(key0), .key_valid(key_valid0), .err(err0), .spent(spent0)
  );

  qkd_pair_bank_sched #(.NUM_PAIRS(2), .KEY_BYTES(4), .TIMEOUT(255)) dut_small (
    .clk(clk), .reset(reset), .start(start1), .abort(1'b0), .bus(bus1),
    .busy(busy1), .key(key1), .key_valid(key_valid1), .err(err1), .spent(spent1)
  );

  always #5 clk = ~clk;

  assign bus0.req_a_valid = va;
  assign bus0.req_b_valid = vb;
  assign bus0.req_a_basis = ba;
  assign bus0.req_b_basis = bb;
  assign bus1.req_a_valid = va;
  assign bus1.req_b_valid = vb;
  assign bus1.req_a_basis = ba;
  assign bus1.req_b_basis = bb;

  // Slot stubs: every slot holds basis 01; large bank slot k returns 3C+k, small A0+k.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      out0a[8*k +: 8] = mm ? 8'h11 : 8'(8'h3C + k);
      out0b[8*k +: 8] = mm ? 8'h22 : 8'(8'h3C + k);
    end
    for (int k = 0; k < 2; k++) begin
      out1a[8*k +: 8] = 8'(8'hA0 + k);
      out1b[8*k +: 8] = 8'(8'hA0 + k);
    end
  end

  assign bus0.pair_out_a     = out0a;
  assign bus0.pair_out_b     = out0b;
  assign bus0.pair_valid_a   = {16{bus0.pair_basis_a == 2'b01}};
  assign bus0.pair_valid_b   = {16{bus0.pair_basis_b == 2'b01}};
  assign bus0.pair_fuse_fire = suppress ? 16'h0000 : fuse0;
  assign bus1.pair_out_a     = out1a;
  assign bus1.pair_out_b     = out1b;
  assign bus1.pair_valid_a   = {2{bus1.pair_basis_a == 2'b01}};
  assign bus1.pair_valid_b   = {2{bus1.pair_basis_b == 2'b01}};
  assign bus1.pair_fuse_fire = fuse1;

  // A slot's fuse latches once it has been read.
  always @(posedge clk) begin
    if (reset) begin
      fuse0 <= 16'h0000;
      fuse1 <= 2'b00;
    end else begin
      fuse0 <= fuse0 | bus0.pair_read_a;
      fuse1 <= fuse1 | bus1.pair_read_a;
    end
  end

  assign rdy_a_m = cur ? bus1.req_a_ready : bus0.req_a_ready;
  assign rdy_b_m = cur ? bus1.req_b_ready : bus0.req_b_ready;
  assign resv_m  = cur ? bus1.res_valid   : bus0.res_valid;
  assign ress_m  = cur ? bus1.res_sifted  : bus0.res_sifted;
  assign init_m  = cur ? {14'b0, bus1.pair_init} : bus0.pair_init;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input bit which);
    if (which) start1 = 1'b1;
    else       start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // One round; returns at the CONFIRM negedge, or the DONE negedge when aborted in MEASURE.
  task automatic round(input logic [1:0] a, input logic [1:0] b, input int exp_sift,
                       input logic [15:0] exp_init, input bit abort_meas);
    int t = 0;
    while (!(rdy_a_m && rdy_b_m) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready", {31'b0, rdy_a_m & rdy_b_m}, 32'd1);
    va = 1'b1; vb = 1'b1; ba = a; bb = b;
    @(negedge clk);
    va = 1'b0; vb = 1'b0;
    chk("pair_init", {16'b0, init_m}, {16'b0, exp_init});
    @(negedge clk);
    if (abort_meas) begin
      abort0 = 1'b1;
      @(negedge clk);
      abort0 = 1'b0;
    end else begin
      @(negedge clk);
      chk("res_valid", {31'b0, resv_m}, 32'd1);
      if (exp_sift >= 0) chk("res_sifted", {31'b0, ress_m}, 32'(exp_sift));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  saw_init;
    cur = 1'b0; suppress = 1'b0; mm = 1'b0;
    start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0;
    va = 1'b0; vb = 1'b0; ba = 2'b00; bb = 2'b00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'b0, busy0}, 32'd0);
    chk("rst_key", key0, 32'd0);
    chk("rst_err", {29'b0, err0}, 32'd0);
    chk("rst_spent", {16'b0, spent0}, 32'd0);
    chk("rst_ready", {31'b0, bus0.req_a_ready}, 32'd0);

    // Full session: slots 0..3 all sift.
    kick(1'b0);
    for (int r = 0; r < 4; r++) round(2'b01, 2'b01, 1, 16'(1 << r), 1'b0);
    @(negedge clk);
    chk("sess_key", key0, 32'h3C3D3E3F);
    chk("sess_err", {29'b0, err0}, 32'd0);
    chk("sess_kv", {31'b0, key_valid0}, 32'd1);
    chk("sess_spent", {16'b0, spent0}, 32'h000F);
    chk("sess_busy", {31'b0, busy0}, 32'd0);

    // Basis disagreement discards the round; then abort during MEASURE.
    kick(1'b0);
    round(2'b01, 2'b10, 0, 16'h0010, 1'b0);
    @(negedge clk);
    chk("disc_spent", {16'b0, spent0}, 32'h001F);
    chk("disc_key", key0, 32'd0);
    chk("disc_busy", {31'b0, busy0}, 32'd1);
    round(2'b01, 2'b01, -1, 16'h0020, 1'b1);
    chk("abort_err", {29'b0, err0}, 32'd5);
    chk("abort_spent", {16'b0, spent0}, 32'h003F);
    chk("abort_busy", {31'b0, busy0}, 32'd0);
    chk("abort_kv", {31'b0, key_valid0}, 32'd0);

    // Fuse never fires.
    suppress = 1'b1;
    kick(1'b0);
    round(2'b01, 2'b01, -1, 16'h0040, 1'b0);
    @(negedge clk);
    suppress = 1'b0;
    chk("fault_err", {29'b0, err0}, 32'd4);
    chk("fault_busy", {31'b0, busy0}, 32'd0);

    // Both valid, different bytes.
    mm = 1'b1;
    kick(1'b0);
    round(2'b01, 2'b01, 0, 16'h0080, 1'b0);
    @(negedge clk);
    mm = 1'b0;
    chk("mm_err", {29'b0, err0}, 32'd3);
    chk("mm_kv", {31'b0, key_valid0}, 32'd0);
    chk("mm_spent", {16'b0, spent0}, 32'h00FF);

    // Only party A handshakes.
    kick(1'b0);
    va = 1'b1; ba = 2'b01;
    @(negedge clk);
    va = 1'b0;
    cyc = 0;
    saw_init = 1'b0;
    while (busy0 && cyc < 400) begin
      if (bus0.pair_init != 16'h0000) saw_init = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk("to_err", {29'b0, err0}, 32'd2);
    chk("to_busy", {31'b0, busy0}, 32'd0);
    chk("to_no_init", {31'b0, saw_init}, 32'd0);
    chk("to_len", {31'b0, (cyc >= 250 && cyc <= 260)}, 32'd1);

    // start together with abort from DONE: nothing begins.
    start0 = 1'b1; abort0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; abort0 = 1'b0;
    chk("sa_busy", {31'b0, busy0}, 32'd0);
    chk("sa_err", {29'b0, err0}, 32'd2);

    // Two-slot bank runs out before the key is complete.
    cur = 1'b1;
    kick(1'b1);
    round(2'b01, 2'b01, 1, 16'h0001, 1'b0);
    round(2'b01, 2'b01, 1, 16'h0002, 1'b0);
    @(negedge clk);
    chk("ex_err", {29'b0, err1}, 32'd1);
    chk("ex_spent", {30'b0, spent1}, 32'd3);
    chk("ex_key", key1, 32'h0000A0A1);
    chk("ex_kv", {31'b0, key_valid1}, 32'd0);
    kick(1'b1);
    chk("ex2_err", {29'b0, err1}, 32'd1);
    chk("ex2_key", key1, 32'd0);
    chk("ex2_busy", {31'b0, busy1}, 32'd0);

    // Reset in the middle of WAIT_REQ.
    cur = 1'b0;
    kick(1'b0);
    @(negedge clk);
    chk("wr_busy", {31'b0, busy0}, 32'd1);
    chk("wr_ready", {31'b0, bus0.req_a_ready}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_busy", {31'b0, busy0}, 32'd0);
    chk("mr_err", {29'b0, err0}, 32'd0);
    chk("mr_spent", {16'b0, spent0}, 32'd0);
    chk("mr_ready", {31'b0, bus0.req_a_ready}, 32'd0);
    chk("mr_spent_small", {30'b0, spent1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/qkd_pair_bank_sched.md
# qkd_pair_bank_sched

Session scheduler for a bank of `NUM_PAIRS` `qkd_entangled_pair` slots. Each pair slot yields exactly one measurement per reset, because collapse latches its kill permanently. The block collects one basis choice per round from party A and party B, then selects the lowest-index unspent slot. It issues init, then a simultaneous A/B read, and sifts the result. It accumulates `KEY_BYTES` sifted bytes into a shared key and sits between the party interfaces and the pair bank.

## Interface
- `NUM_PAIRS`, 16: number of pair slots in the bank (≥2).
- `KEY_BYTES`, 4: sifted bytes per session.
- `TIMEOUT`, 255: maximum cycles to wait for both basis requests in a round.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high. Clears all state, including the spent map, because the bank shares this reset.
- `start` in 1: begin session; ignored unless state is IDLE or DONE.
- `abort` in 1: terminate the session (err=ABORT).
- `req_a_valid`/`req_a_ready`/`req_a_basis` in/out/in 1/1/2: party A basis handshake.
- `req_b_valid`/`req_b_ready`/`req_b_basis` in/out/in 1/1/2: party B basis handshake.
- `res_valid` out 1: one-cycle round result pulse to both parties.
- `res_sifted` out 1: the round produced a key byte.
- `pair_init` out NUM_PAIRS: one-hot init strobe.
- `pair_read_a`, `pair_read_b` out NUM_PAIRS: one-hot read strobes.
- `pair_basis_a`, `pair_basis_b` out 2: shared basis buses to all slots.
- `pair_out_a`, `pair_out_b` in 8*NUM_PAIRS: slot k occupies bits [8k+7:8k].
- `pair_valid_a`, `pair_valid_b`, `pair_fuse_fire` in NUM_PAIRS: per-slot status.
- `busy` out 1: session in progress.
- `key` out 8*KEY_BYTES: assembled key; the newest byte enters at [7:0].
- `key_valid` out 1: level; high in DONE with err=OK.
- `err` out 3: OK=0, EXHAUSTED=1, TIMEOUT=2, MISMATCH=3, FAULT=4, ABORT=5.
- `spent` out NUM_PAIRS: sticky consumed-slot map.
- Reset value of every output is 0.

## Operation
- States: IDLE, WAIT_REQ, INIT, MEASURE, CONFIRM, DONE.
- IDLE/DONE to WAIT_REQ on `start`:
  - Clears `key`, byte count, `err` and `key_valid`.
  - If `spent` is all-ones, goes straight to DONE with err=EXHAUSTED.
- WAIT_REQ:
  - `req_x_ready` is high while party x's basis is not yet latched.
  - A handshake (valid&ready) latches that basis.
  - Both parties may handshake in the same cycle.
  - When both are latched, select the lowest-index unspent slot and go to INIT.
  - The wait counter starts at 0 on WAIT_REQ entry. If it reaches TIMEOUT before both bases are latched, go to DONE with err=TIMEOUT.
- INIT: `pair_init[slot]`=1 for one cycle, then MEASURE.
- MEASURE:
  - `pair_read_a[slot]` and `pair_read_b[slot]` are 1 for one cycle; the basis buses carry the latched bases.
  - Capture the slot's out/valid in the same cycle.
  - Set `spent[slot]` regardless of outcome.
- CONFIRM:
  - `pair_fuse_fire[slot]` must be 1; otherwise DONE with err=FAULT (slot already dead or tampered).
  - Sift rules:
    - Both captured valids =1 and bytes equal: shift the byte into `key`, increment the count, `res_sifted`=1.
    - Both valid and bytes differ: DONE with err=MISMATCH.
    - Otherwise: discard the round, `res_sifted`=0.
  - `res_valid` pulses in CONFIRM.
  - Next state:
    - Count reaches KEY_BYTES: DONE with err=OK.
    - Else no unspent slot left: DONE with err=EXHAUSTED.
    - Else WAIT_REQ, with latched bases cleared.
- `abort` in any non-IDLE/DONE state goes to DONE with err=ABORT next cycle.
  - An init or read already issued stands; `spent` is updated if MEASURE was active.
- `busy` = state not in {IDLE, DONE}.
- When err≠OK, `key` holds the partial bytes and `key_valid`=0.

## Timing
- All outputs are registered except the `pair_*` strobes, which decode combinationally from state and slot.
- Round latency from the second basis handshake: INIT at +1, MEASURE at +2, CONFIRM at +3.
  - `res_valid` is high in CONFIRM.
  - The next `req_*_ready` is high at +4.
- Minimum session length is 4*KEY_BYTES+1 cycles.
- `abort` takes priority over every other transition in the same cycle.
- `start` and `abort` in the same cycle: `abort` wins (no session begins).
- Reset mid-session: IDLE next cycle; all outputs and `spent` are 0.

## Structure
- Package `qkd_pkg`:
  - `sched_state_e` state enum.
  - `sched_err_e` error enum.
  - Byte width constant = 8.
  - Basis width constant = 2.
- Sub-module `qkd_slot_pick`: a combinational lowest-index-zero priority encoder over `spent`, producing index plus `none_free`.

## Test plan
- Pair stubs with programmable basis/value.
  - Stimulus: every slot has basis 2'b01 and value 8'h3C+k; both parties send 2'b01 for 4 rounds.
  - Response: `key`=32'h3C3D3E3F, err=OK, `spent`=16'h000F.
- Sift discard:
  - Stimulus: A sends 2'b01, B sends 2'b10, slot basis 2'b01.
  - Response: `res_sifted`=0, byte count unchanged, slot still marked spent.
- Timeout:
  - Stimulus: only A handshakes; B idle for 255 cycles.
  - Response: err=TIMEOUT, `busy`=0, no `pair_init` pulse.
- Exhaustion:
  - Stimulus: NUM_PAIRS=2, KEY_BYTES=4, all rounds sifted.
  - Response: err=EXHAUSTED after 2 rounds, `spent`=2'b11. A subsequent `start` goes to DONE/EXHAUSTED in 1 cycle.
- Fault and mismatch:
  - Stimulus: stub suppresses `fuse_fire`.
  - Response: err=FAULT.
  - Stimulus: stub returns A=8'h11, B=8'h22, both valid.
  - Response: err=MISMATCH.
- Abort and reset:
  - Stimulus: `abort` during MEASURE.
  - Response: err=ABORT, that slot spent.
  - Stimulus: `reset` mid-WAIT_REQ.
  - Response: all outputs 0 on the next cycle.
